vga_fb_mem: RTL and testbench
=============================

# vga_fb_mem

Parametrised dual-port frame-buffer memory for the VGA path. Generalised successor of the team's 8-bit/64K VGA RAM. Port A is the game-logic read/write port, with a per-bit write mask. Port B is the scan-out read port, with write-to-read forwarding. The block adds a selectable output pipeline stage and a hardware region-fill engine, so the game logic can clear or paint a span of addresses without issuing one write per word.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 16: address width; depth is 2**ADDR_WIDTH.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register stage for 2-cycle latency on both ports.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr_a  in  ADDR_WIDTH  port A address.
- data_a  in  DATA_WIDTH  port A write data.
- wmask_a  in  DATA_WIDTH  per-bit write enable; 1 means that bit is written.
- we_a  in  1  port A write request.
- a_wr_ready  out  1  high when a port A write will be accepted; equals !fill_busy.
- q_a  out  DATA_WIDTH  port A read data.
- addr_b  in  ADDR_WIDTH  port B (read-only) address.
- q_b  out  DATA_WIDTH  port B read data.
- fill_start  in  1  single-cycle request to start a fill.
- fill_lo, fill_hi  in  ADDR_WIDTH  inclusive fill range, latched on start.
- fill_value  in  DATA_WIDTH  fill word, latched on start; written full-width, no mask.
- fill_busy  out  1  high while the fill engine owns the write path.
- fill_done  out  1  one-cycle pulse after the last fill write.

## Operation
- Storage: ram[2**ADDR_WIDTH]. Simulation init sets ram[i] = i[DATA_WIDTH-1:0]. Reset never alters contents.
- Port A write is accepted when we_a && a_wr_ready. The new word is (ram[addr_a] & ~wmask_a) | (data_a & wmask_a). In that cycle q_a returns the new word (write-through).
- Port A read (no accepted write): q_a = ram[addr_a].
- we_a while fill_busy is ignored: no RAM change, and q_a returns ram[addr_a] as a normal read.
- Port B forwarding: q_b = ram[addr_b], except when a write lands on addr_b in the same cycle. In that case q_b returns the newly written word, whether the write comes from port A or the fill engine.
- Fill FSM states:
  - IDLE: on fill_start, latch lo/hi/value and set ptr=lo, then go to FILL. fill_start while not IDLE is ignored.
  - FILL: each cycle write ram[ptr]=value, then ptr=ptr+1 modulo 2**ADDR_WIDTH. When ptr==hi is written, go to DONE.
  - DONE: fill_done=1 for one cycle, then return to IDLE.
- Range rules:
  - lo==hi writes exactly one word.
  - hi<lo wraps through the top address to 0; count = 2**ADDR_WIDTH - lo + hi + 1.
  - lo=0, hi=max covers the full memory.
- Port A reads remain serviced during FILL.
- fill_busy = (state==FILL).

## Timing
- Reset values: q_a=0, q_b=0, both pipeline stages cleared, state=IDLE, fill_busy=0, fill_done=0, a_wr_ready=1.
- Read latency: address at edge N gives data valid after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1). Forwarded data follows the same latency.
- Fill start is sampled at edge N:
  - fill_busy is high from N+1.
  - The first fill write commits at edge N+2; the last of k writes commits at edge N+1+k.
  - fill_done is high for the cycle following the last write, with fill_busy low in that cycle.
- fill_start with we_a in the same IDLE cycle: the port A write is accepted in that cycle; later fill writes overwrite it if it lies in range.
- a_wr_ready falls the cycle after fill_start and rises in the fill_done cycle.
- Reset mid-fill: returns to IDLE next edge with no fill_done pulse; words already written stay written.

## Test plan
- Reset then read: ADDR_WIDTH=4, OUT_REG=0; read addr_b=5 -> q_b=0x05 one cycle later; q_a=q_b=0 during reset.
- Masked write with forwarding: ram[3]=0x03; we_a, addr_a=3, data_a=0xF0, wmask_a=0xC0, addr_b=3 -> q_a=q_b=0xC3 the same cycle; a later read of 3 -> 0xC3.
- Wrapping fill: lo=14, hi=1, value=0xAA -> fill_busy high for exactly 4 cycles; addresses 14,15,0,1 read 0xAA, address 2 reads 0x02; single fill_done pulse; port A we_a=1 to addr 7 during busy -> ignored, ram[7]=0x07.
- Single-word fill and start collision: lo=hi=9 with we_a to addr 9 data 0x11 in the same cycle -> ram[9] ends 0xAA, busy for 1 cycle; fill_start during busy ignored.
- Reset mid-fill: lo=0, hi=15, assert rst after 3 writes -> addresses 0..2 = value, 3 = 0x03, no fill_done, a_wr_ready=1 next cycle.
- OUT_REG=1: address at edge N -> data at N+2; back-to-back port B reads stream one word per cycle.

Source files
------------

// File: rtl/vga_fb_mem.sv
`timescale 1ns / 1ps
// vga_fb_mem: dual-port frame-buffer RAM with a region-fill engine.
//   Port A (addr_a/data_a/wmask_a/we_a -> q_a): game-logic read/write with a
//     per-bit write mask and write-through read data. Writes are refused while
//     a fill is running (a_wr_ready low).
//   Port B (addr_b -> q_b): scan-out read. It forwards any word being written
//     to the same address in the same cycle.
//   Fill (fill_start/fill_lo/fill_hi/fill_value -> fill_busy/fill_done):
//     writes fill_value to the inclusive range lo..hi, one word per cycle,
//     wrapping through the top address when hi < lo.
//   OUT_REG=1 adds a second output register on both read ports.
module vga_fb_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] wmask_a,
    input  logic                  we_a,
    output logic                  a_wr_ready,
    output logic [DATA_WIDTH-1:0] q_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] q_b,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_lo,
    input  logic [ADDR_WIDTH-1:0] fill_hi,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];
    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    // Power-up image: each word holds its own (truncated) address.
    function automatic mem_t init_mem();
        mem_t m;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            m[i] = DATA_WIDTH'(i);
        end
        return m;
    endfunction

    mem_t mem_q = init_mem();

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   val_q, val_d;
    logic [DATA_WIDTH-1:0]   q_a_q, q_a_d;
    logic [DATA_WIDTH-1:0]   q_b_q, q_b_d;

    logic                    fill_we;
    logic                    a_we;
    logic [DATA_WIDTH-1:0]   a_word;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    // Fill sequencer next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hi_d    = hi_q;
        val_d   = val_q;
        fill_we = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fill_start) begin
                    state_d = StFill;
                    ptr_d   = fill_lo;
                    hi_d    = fill_hi;
                    val_d   = fill_value;
                end
            end
            StFill: begin
                fill_we = 1'b1;
                // Natural wrap of the pointer handles hi < lo ranges.
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == hi_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Single write path shared by port A and the fill engine; they never
    // overlap because port A is refused while filling. Reset blocks all writes
    // so a fill interrupted by reset leaves the current word untouched.
    always_comb begin
        a_wr_ready = (state_q != StFill);
        a_we       = we_a && a_wr_ready && !rst;
        a_word     = (mem_q[addr_a] & ~wmask_a) | (data_a & wmask_a);
        wr_en      = (fill_we && !rst) || a_we;
        wr_addr    = fill_we ? ptr_q : addr_a;
        wr_data    = fill_we ? val_q : a_word;
        q_a_d      = a_we ? a_word : mem_q[addr_a];
        q_b_d      = (wr_en && (wr_addr == addr_b)) ? wr_data : mem_q[addr_b];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            hi_q    <= '0;
            val_q   <= '0;
            q_a_q   <= '0;
            q_b_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hi_q    <= hi_d;
            val_q   <= val_d;
            q_a_q   <= q_a_d;
            q_b_q   <= q_b_d;
        end
    end

    assign fill_busy = (state_q == StFill);
    assign fill_done = (state_q == StDone);

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] q_a2_q;
        logic [DATA_WIDTH-1:0] q_b2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q_a2_q <= '0;
                q_b2_q <= '0;
            end else begin
                q_a2_q <= q_a_q;
                q_b2_q <= q_b_q;
            end
        end

        assign q_a = q_a2_q;
        assign q_b = q_b2_q;
    end else begin : g_no_out_reg
        assign q_a = q_a_q;
        assign q_b = q_b_q;
    end

endmodule

// File: tb/tb_vga_fb_mem.sv
`timescale 1ns / 1ps
// Bench for vga_fb_mem: two instances (OUT_REG=0 and OUT_REG=1, 16 x 8 bits)
// share every input. Stimulus pushes expected outputs tagged with the cycle
// they must appear in; a negedge monitor pops and compares them.
module tb_vga_fb_mem;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    localparam int QA    = 0;
    localparam int QB    = 1;
    localparam int BUSY  = 2;
    localparam int DONE  = 3;
    localparam int RDY   = 4;
    localparam int QA1   = 5;
    localparam int QB1   = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr_a, addr_b, fill_lo, fill_hi;
    logic [DW-1:0] data_a, wmask_a, fill_value;
    logic          we_a, fill_start;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
    logic          busy0, done0, ready0, busy1, done1, ready1;

    vga_fb_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .addr_a(addr_a), .data_a(data_a), .wmask_a(wmask_a),
        .we_a(we_a), .a_wr_ready(ready0), .q_a(q_a0), .addr_b(addr_b), .q_b(q_b0),
        .fill_start(fill_start), .fill_lo(fill_lo), .fill_hi(fill_hi),
        .fill_value(fill_value), .fill_busy(busy0), .fill_done(done0)
    );

    vga_fb_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .addr_a(addr_a), .data_a(data_a), .wmask_a(wmask_a),
        .we_a(we_a), .a_wr_ready(ready1), .q_a(q_a1), .addr_b(addr_b), .q_b(q_b1),
        .fill_start(fill_start), .fill_lo(fill_lo), .fill_hi(fill_hi),
        .fill_value(fill_value), .fill_busy(busy1), .fill_done(done1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        int            sel;
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input int d, input int sel, input logic [DW-1:0] e,
                            input string nm);
        exp_t x;
        x.due  = cyc + d;
        x.sel  = sel;
        x.exp  = e;
        x.name = nm;
        sb.push_back(x);
    endtask

    function automatic logic [DW-1:0] actual(input int sel);
        case (sel)
            QA:      return q_a0;
            QB:      return q_b0;
            BUSY:    return {7'b0, busy0};
            DONE:    return {7'b0, done0};
            RDY:     return {7'b0, ready0};
            QA1:     return q_a1;
            QB1:     return q_b1;
            default: return 'x;
        endcase
    endfunction

    // Monitor: compare every entry due in the current cycle.
    always @(negedge clk) begin
        logic [DW-1:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                act = actual(sb[i].sel);
                checks++;
                if (act !== sb[i].exp) begin
                    $display("FAIL %s (cycle %0d): got %h, expected %h",
                             sb[i].name, cyc, act, sb[i].exp);
                    errors++;
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: never compared (due cycle %0d)", sb[i].name, sb[i].due);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] stream_addr [5];
    logic [DW-1:0] stream_exp  [5];

    initial begin
        rst = 1'b1; we_a = 1'b0; fill_start = 1'b0;
        addr_a = '0; addr_b = 4'd5; data_a = '0; wmask_a = '0;
        fill_lo = '0; fill_hi = '0; fill_value = '0;
        stream_addr = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        stream_exp  = '{8'h04, 8'h05, 8'h5A, 8'h07, 8'h08};

        // Reset state.
        tick(); tick();
        push_exp(0, QA, 8'h00, "reset_q_a");
        push_exp(0, QB, 8'h00, "reset_q_b");
        push_exp(0, BUSY, 8'h00, "reset_busy");
        push_exp(0, DONE, 8'h00, "reset_done");
        push_exp(0, RDY, 8'h01, "reset_ready");
        push_exp(0, QB1, 8'h00, "reset_q_b_outreg");
        tick();

        // Plain reads after reset.
        rst = 1'b0; addr_b = 4'd5; addr_a = 4'd5;
        push_exp(1, QB, 8'h05, "read_b_5");
        push_exp(1, QA, 8'h05, "read_a_5");
        tick();

        // Masked write to 3 with B forwarding: (03 & 3F) | (F0 & C0) = C3.
        we_a = 1'b1; addr_a = 4'd3; data_a = 8'hF0; wmask_a = 8'hC0; addr_b = 4'd3;
        push_exp(1, QA, 8'hC3, "masked_wr_q_a");
        push_exp(1, QB, 8'hC3, "masked_wr_fwd_b");
        push_exp(2, QB1, 8'hC3, "masked_wr_fwd_b_outreg");
        tick();
        addr_a = 4'd6; data_a = 8'h5A; wmask_a = 8'hFF; addr_b = 4'd2;
        push_exp(1, QA, 8'h5A, "full_wr_q_a");
        push_exp(1, QB, 8'h02, "other_addr_b");
        tick();
        we_a = 1'b0; addr_a = 4'd3; addr_b = 4'd6;
        push_exp(1, QA, 8'hC3, "reread_3");
        push_exp(1, QB, 8'h5A, "reread_6");
        push_exp(2, QB1, 8'h5A, "reread_6_outreg");
        tick();

        // Wrapping fill 14..1 = AA, four writes.
        addr_b = 4'd0; fill_lo = 4'd14; fill_hi = 4'd1; fill_value = 8'hAA; fill_start = 1'b1;
        push_exp(0, BUSY, 8'h00, "wrap_busy_pre");
        push_exp(1, BUSY, 8'h01, "wrap_busy_first");
        push_exp(4, BUSY, 8'h01, "wrap_busy_last");
        push_exp(5, BUSY, 8'h00, "wrap_busy_at_done");
        push_exp(4, DONE, 8'h00, "wrap_done_early");
        push_exp(5, DONE, 8'h01, "wrap_done_pulse");
        push_exp(6, DONE, 8'h00, "wrap_done_single");
        push_exp(1, RDY, 8'h00, "wrap_ready_low");
        push_exp(5, RDY, 8'h01, "wrap_ready_back");
        tick();
        // Busy: this start and this port A write must both be ignored.
        fill_lo = 4'd3; fill_hi = 4'd3; fill_value = 8'h55;
        we_a = 1'b1; addr_a = 4'd7; data_a = 8'h33; wmask_a = 8'hFF;
        push_exp(1, QA, 8'h07, "busy_wr_reads_old");
        tick();
        fill_start = 1'b0; we_a = 1'b0; addr_b = 4'd15;
        push_exp(1, QB, 8'hAA, "fill_fwd_b_15");
        tick(); tick(); tick(); tick();
        addr_a = 4'd14; addr_b = 4'd15;
        push_exp(1, QA, 8'hAA, "wrap_14");
        push_exp(1, QB, 8'hAA, "wrap_15");
        tick();
        addr_a = 4'd0; addr_b = 4'd1;
        push_exp(1, QA, 8'hAA, "wrap_0");
        push_exp(1, QB, 8'hAA, "wrap_1");
        tick();
        addr_a = 4'd2; addr_b = 4'd7;
        push_exp(1, QA, 8'h02, "wrap_2_untouched");
        push_exp(1, QB, 8'h07, "busy_wr_7_ignored");
        tick();
        addr_a = 4'd3; addr_b = 4'd13;
        push_exp(1, QA, 8'hC3, "busy_start_ignored");
        push_exp(1, QB, 8'h0D, "wrap_13_untouched");
        tick();

        // Single-word fill colliding with a port A write to the same word.
        addr_a = 4'd9; we_a = 1'b1; data_a = 8'h11; wmask_a = 8'hFF;
        fill_lo = 4'd9; fill_hi = 4'd9; fill_value = 8'hAA; fill_start = 1'b1;
        push_exp(1, QA, 8'h11, "collide_wr_through");
        push_exp(1, BUSY, 8'h01, "single_busy");
        push_exp(2, BUSY, 8'h00, "single_busy_one_cycle");
        push_exp(2, DONE, 8'h01, "single_done");
        tick();
        we_a = 1'b0; fill_start = 1'b0; addr_b = 4'd9;
        push_exp(1, QB, 8'hAA, "single_fill_fwd_b");
        tick(); tick();
        addr_a = 4'd9;
        push_exp(1, QA, 8'hAA, "single_fill_overwrites");
        tick();

        // Reset after three writes of a full-range fill.
        fill_lo = 4'd0; fill_hi = 4'd15; fill_value = 8'h77; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        push_exp(0, BUSY, 8'h00, "midfill_rst_busy");
        push_exp(0, RDY, 8'h01, "midfill_rst_ready");
        push_exp(0, DONE, 8'h00, "midfill_rst_no_done");
        rst = 1'b0;
        push_exp(1, DONE, 8'h00, "midfill_no_done_later");
        push_exp(1, BUSY, 8'h00, "midfill_stays_idle");
        addr_a = 4'd0; addr_b = 4'd1;
        push_exp(1, QA, 8'h77, "midfill_0");
        push_exp(1, QB, 8'h77, "midfill_1");
        tick();
        addr_a = 4'd2; addr_b = 4'd3;
        push_exp(1, QA, 8'h77, "midfill_2");
        push_exp(1, QB, 8'hC3, "midfill_3_kept");
        tick();
        addr_a = 4'd4;
        push_exp(1, QA, 8'h04, "midfill_4_kept");
        tick();

        // Back-to-back streaming: 1-cycle and 2-cycle latency instances.
        addr_a = 4'd10;
        push_exp(1, QA, 8'h0A, "lat1_q_a");
        push_exp(2, QA1, 8'h0A, "lat2_q_a");
        for (int i = 0; i < 5; i++) begin
            addr_b = stream_addr[i];
            push_exp(1, QB, stream_exp[i], $sformatf("stream_b_%0d", i));
            push_exp(2, QB1, stream_exp[i], $sformatf("stream_b_outreg_%0d", i));
            tick();
        end

        repeat (4) tick();
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
